// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults, fill state encoding and width helper for seq_det_pattern
package seq_det_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // 11x1 detector: bit 1 of the pattern is a don't-care
    localparam logic [3:0] PAT_INIT_11X1  = 4'b1101;
    localparam logic [3:0] MASK_INIT_11X1 = 4'b1101;

    localparam logic FILLING = 1'b0;
    localparam logic ARMED   = 1'b1;

    function automatic int fill_w(input int pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/seq_det_pattern_if.sv
// rtl/seq_det_pattern_if.sv - serial sample, pattern load and hit count signals of seq_det_pattern
interface seq_det_pattern_if #(
    parameter int PAT_W = seq_det_pkg::PAT_W_DEF,
    parameter int CNT_W = seq_det_pkg::CNT_W_DEF
);
    logic             i_valid;
    logic             i_seq;
    logic             i_load;
    logic [PAT_W-1:0] i_pattern;
    logic [PAT_W-1:0] i_mask;
    logic             i_overlap;
    logic             i_clr_cnt;
    logic             o_seq_detect;
    logic [CNT_W-1:0] o_hit_count;

    modport master (
        output i_valid, i_seq, i_load, i_pattern, i_mask, i_overlap, i_clr_cnt,
        input  o_seq_detect, o_hit_count
    );

    modport slave (
        input  i_valid, i_seq, i_load, i_pattern, i_mask, i_overlap, i_clr_cnt,
        output o_seq_detect, o_hit_count
    );
endinterface

// File: rtl/seq_det_hit_cnt.sv
// rtl/seq_det_hit_cnt.sv - saturating hit counter, clear has priority over increment
module seq_det_hit_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_pattern.sv
// rtl/seq_det_pattern.sv - programmable Mealy pattern detector with masking; SEQ_DET_HIT_CNT_EN adds a hit counter
module seq_det_pattern
    import seq_det_pkg::*;
#(
    parameter int             PAT_W     = PAT_W_DEF,
    parameter int             CNT_W     = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_INIT  = PAT_W'(PAT_INIT_11X1),
    parameter logic [PAT_W-1:0] MASK_INIT = PAT_W'(MASK_INIT_11X1)
) (
    input  logic              clk,
    input  logic              rst,
    seq_det_pattern_if.slave  bus
);

    localparam int               FILL_W   = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  mask_r;
    logic              fill_state;
    logic [PAT_W-1:0]  win;
    logic              detect;

    always_comb begin
        fill_state = (fill == FILL_MAX) ? ARMED : FILLING;
        win        = {hist, bus.i_seq};
        detect     = bus.i_valid & (fill_state == ARMED) & ~bus.i_load &
                     (((win ^ pat_r) & mask_r) == '0);
    end

    assign bus.o_seq_detect = detect;

    // A load discards the sample of its cycle, so hist is left untouched then
    always_ff @(posedge clk) begin
        if (rst) begin
            hist   <= '0;
            fill   <= '0;
            pat_r  <= PAT_INIT;
            mask_r <= MASK_INIT;
        end else if (bus.i_load) begin
            pat_r  <= bus.i_pattern;
            mask_r <= bus.i_mask;
            fill   <= '0;
        end else if (bus.i_valid) begin
            hist <= win[PAT_W-2:0];
            if (detect && !bus.i_overlap) begin
                fill <= '0;
            end else if (fill_state == FILLING) begin
                fill <= fill + 1'b1;
            end
        end
    end

`ifdef SEQ_DET_HIT_CNT_EN
    seq_det_hit_cnt #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.i_clr_cnt),
        .inc   (detect),
        .count (bus.o_hit_count)
    );
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt  = bus.i_clr_cnt;
    assign bus.o_hit_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_pattern.sv
// tb/tb_seq_det_pattern.sv - directed self-checking bench for seq_det_pattern
module tb_seq_det_pattern;

`ifdef SEQ_DET_HIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    seq_det_pattern_if #(.PAT_W(4), .CNT_W(8)) bus();
    seq_det_pattern_if #(.PAT_W(4), .CNT_W(2)) bus2();

    seq_det_pattern #(.PAT_W(4), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_det_pattern #(.PAT_W(4), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; detect is sampled 1 ns later
    task automatic cyc(input logic v, input logic s, input logic ld, output logic det);
        bus.i_valid = v;
        bus.i_seq   = s;
        bus.i_load  = ld;
        #1 det = bus.o_seq_detect;
        @(negedge clk);
        bus.i_load  = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    task automatic cyc2(input logic v, input logic s, input logic ld, output logic det);
        bus2.i_valid = v;
        bus2.i_seq   = s;
        bus2.i_load  = ld;
        #1 det = bus2.o_seq_detect;
        @(negedge clk);
        bus2.i_load  = 1'b0;
        bus2.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic det;
        do_reset();
        n_checks++;
        if (bus.o_hit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.o_hit_count);
        end
        n_checks++;
        if (bus2.o_hit_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_count2: got %0d expected 0", bus2.o_hit_count);
        end
        cyc(1'b1, 1'b1, 1'b0, det);
        n_checks++;
        if (det !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_detect: got %0b expected 0", det);
        end
        do_reset();
        exp_cnt = 0;
    endtask

    task automatic test_default_nonoverlap();
        logic       det;
        logic [7:0] bits = 8'b1101_1111;
        logic [7:0] exp  = 8'b0001_0001;
        bus.i_overlap = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, det);
            n_checks++;
            if (det !== exp[i]) begin
                n_fail++;
                $display("FAIL nonoverlap_bit%0d: got %0b expected %0b", 8 - i, det, exp[i]);
            end
        end
        exp_cnt = exp_cnt + 2;
        n_checks++;
        if (bus.o_hit_count !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin
            n_fail++;
            $display("FAIL nonoverlap_count: got %0d expected %0d", bus.o_hit_count, CNT_EN ? exp_cnt : 0);
        end
    endtask

    task automatic test_overlap();
        logic       det;
        logic [6:0] bits   = 7'b0101010;
        logic [6:0] exp_ov = 7'b0001010;
        logic [6:0] exp_no = 7'b0001000;
        bus.i_pattern = 4'b0101;
        bus.i_mask    = 4'b1111;
        for (int pass = 0; pass < 2; pass++) begin
            bus.i_overlap = (pass == 0);
            cyc(1'b0, 1'b0, 1'b1, det);
            for (int i = 6; i >= 0; i--) begin
                cyc(1'b1, bits[i], 1'b0, det);
                n_checks++;
                if (det !== ((pass == 0) ? exp_ov[i] : exp_no[i])) begin
                    n_fail++;
                    $display("FAIL overlap%0d_bit%0d: got %0b expected %0b", 1 - pass, 7 - i, det,
                             (pass == 0) ? exp_ov[i] : exp_no[i]);
                end
            end
        end
        exp_cnt = exp_cnt + 3;
        n_checks++;
        if (bus.o_hit_count !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin
            n_fail++;
            $display("FAIL overlap_count: got %0d expected %0d", bus.o_hit_count, CNT_EN ? exp_cnt : 0);
        end
    endtask

    task automatic test_valid_gaps();
        logic       det;
        logic [6:0] vld  = 7'b1100011;
        logic [6:0] bits = 7'b1111101;
        logic [6:0] exp  = 7'b0000001;
        bus.i_pattern = 4'b1101;
        bus.i_mask    = 4'b1101;
        bus.i_overlap = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, det);
        for (int i = 6; i >= 0; i--) begin
            cyc(vld[i], bits[i], 1'b0, det);
            n_checks++;
            if (det !== exp[i]) begin
                n_fail++;
                $display("FAIL gaps_cyc%0d: got %0b expected %0b", 7 - i, det, exp[i]);
            end
        end
        exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_load_collision();
        logic       det;
        logic [3:0] bits = 4'b0011;
        logic [3:0] exp  = 4'b0001;
        cyc(1'b1, 1'b1, 1'b0, det);
        cyc(1'b1, 1'b1, 1'b0, det);
        cyc(1'b1, 1'b0, 1'b0, det);
        bus.i_pattern = 4'b0011;
        bus.i_mask    = 4'b1111;
        cyc(1'b1, 1'b1, 1'b1, det);
        n_checks++;
        if (det !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_detect: got %0b expected 0", det);
        end
        n_checks++;
        if (bus.o_hit_count !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin
            n_fail++;
            $display("FAIL collision_count: got %0d expected %0d", bus.o_hit_count, CNT_EN ? exp_cnt : 0);
        end
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, det);
            n_checks++;
            if (det !== exp[i]) begin
                n_fail++;
                $display("FAIL newpat_bit%0d: got %0b expected %0b", 4 - i, det, exp[i]);
            end
        end
    endtask

    task automatic test_counter();
        logic det;
        bus2.i_pattern = 4'b0000;
        bus2.i_mask    = 4'b0000;
        bus2.i_overlap = 1'b1;
        cyc2(1'b0, 1'b0, 1'b1, det);
        for (int i = 0; i < 10; i++) begin
            cyc2(1'b1, i[0], 1'b0, det);
            n_checks++;
            if (det !== (i >= 3)) begin
                n_fail++;
                $display("FAIL anymask_cyc%0d: got %0b expected %0b", i, det, i >= 3);
            end
            if (i == 5) begin
                n_checks++;
                if (bus2.o_hit_count !== (CNT_EN ? 2'd3 : 2'd0)) begin
                    n_fail++;
                    $display("FAIL cnt_three: got %0d expected %0d", bus2.o_hit_count, CNT_EN ? 3 : 0);
                end
            end
        end
        n_checks++;
        if (bus2.o_hit_count !== (CNT_EN ? 2'd3 : 2'd0)) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0d expected %0d", bus2.o_hit_count, CNT_EN ? 3 : 0);
        end
        bus2.i_clr_cnt = 1'b1;
        cyc2(1'b1, 1'b1, 1'b0, det);
        bus2.i_clr_cnt = 1'b0;
        n_checks++;
        if (bus2.o_hit_count !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_clr_wins: got %0d expected 0", bus2.o_hit_count);
        end
        cyc2(1'b1, 1'b0, 1'b0, det);
        n_checks++;
        if (bus2.o_hit_count !== (CNT_EN ? 2'd1 : 2'd0)) begin
            n_fail++;
            $display("FAIL cnt_after_clr: got %0d expected %0d", bus2.o_hit_count, CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_mid_reset();
        logic       det;
        logic [4:0] bits = 5'b11101;
        logic [4:0] exp  = 5'b00001;
        bus.i_overlap = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, det);
        cyc(1'b1, 1'b1, 1'b0, det);
        cyc(1'b1, 1'b0, 1'b0, det);
        bus.i_pattern = 4'b0000;
        bus.i_mask    = 4'b0000;
        bus.i_clr_cnt = 1'b0;
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, det);
        rst = 1'b0;
        n_checks++;
        if (bus.o_hit_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d expected 0", bus.o_hit_count);
        end
        for (int i = 4; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, det);
            n_checks++;
            if (det !== exp[i]) begin
                n_fail++;
                $display("FAIL midreset_bit%0d: got %0b expected %0b", 5 - i, det, exp[i]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst      = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_seq     = 1'b0;
        bus.i_load    = 1'b0;
        bus.i_pattern = 4'b0000;
        bus.i_mask    = 4'b0000;
        bus.i_overlap = 1'b0;
        bus.i_clr_cnt = 1'b0;
        bus2.i_valid   = 1'b0;
        bus2.i_seq     = 1'b0;
        bus2.i_load    = 1'b0;
        bus2.i_pattern = 4'b0000;
        bus2.i_mask    = 4'b0000;
        bus2.i_overlap = 1'b0;
        bus2.i_clr_cnt = 1'b0;
        @(negedge clk);
        test_reset();
        test_default_nonoverlap();
        test_overlap();
        test_valid_gaps();
        test_load_collision();
        test_counter();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
